zbc_clmul_seq: RTL
==================

Name: zbc_clmul_seq

Overview:
- Iterative carry-less multiply unit for the Zbc instructions clmul, clmulh and clmulr.
- Sits in the execute stage beside the combinational Zbb unit and shares the rd writeback mux with it.
- Decodes its own instruction fields; the core asserts start when the instruction is issued and stalls while busy is high.
- Unlike the single-cycle Zbb path, the result arrives after 32/BITS_PER_CYCLE iteration cycles, signalled by a one-cycle done pulse.

Parameters:
BITS_PER_CYCLE, 1, rs2 bits consumed per iteration; legal values 1, 2, 4, 8; latency N = 32/BITS_PER_CYCLE

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  issue strobe from the core, sampled on the rising edge
kill  input  1  synchronous abort (pipeline flush)
din_rs1  input  32  operand rs1
din_rs2  input  32  operand rs2
cmdOp  input  7  instruction opcode field
cmdF3  input  3  instruction funct3 field
cmdF7  input  7  instruction funct7 field
isZbcInstr  output  1  combinational decode flag: opcode 0110011, funct7 0000101, funct3 one of 001 (clmul), 011 (clmulh), 010 (clmulr)
busy  output  1  high while iterating; the core stalls on this
done  output  1  one-cycle pulse; dout_rd is valid in this cycle
dout_rd  output  32  result, held stable until the next accepted start

Behaviour:
- Reset: rst_n low asynchronously forces the state machine to IDLE and clears busy, done, dout_rd, the accumulator, the counter and the operand registers to 0. Any in-flight operation is lost and produces no done.
- isZbcInstr is purely combinational from cmdOp/cmdF3/cmdF7; it is independent of state and of start.
- Accept rule: start & isZbcInstr & ~kill, sampled at a rising edge while in IDLE or DONE.
  - On accept: latch rs1 zero-extended to 64 bits, rs2, and the funct3 select; clear the 64-bit accumulator and the counter; go to RUN.
  - start with a non-Zbc encoding is ignored.
  - start while in RUN is ignored; it is neither queued nor allowed to corrupt the current operation.
- State machine: IDLE, RUN, DONE.
  - RUN iteration: each cycle, for k = 0..BITS_PER_CYCLE-1, if rs2_reg[k] is set then acc ^= (rs1_reg << k). Then rs1_reg <<= BITS_PER_CYCLE, rs2_reg >>= BITS_PER_CYCLE, and the counter increments.
  - After the N-th RUN edge the state goes to DONE.
  - On the transition to DONE, dout_rd is loaded from the final product:
    - clmul = acc[31:0]
    - clmulh = acc[63:32]
    - clmulr = acc[62:31]
  - DONE lasts one cycle, then the state returns to IDLE, unless a new start is accepted in DONE, which goes directly to RUN (back-to-back issue).
- Outputs: busy = (state == RUN); done = (state == DONE).
- Latency: start accepted at edge E0; busy is high from E0 through E_N; done is high between E_N and E_N+1. With BITS_PER_CYCLE = 1, done comes 32 cycles after acceptance.
- Arithmetic: all XOR, no carries. The accumulator is 64 bits and bit 63 is always 0. Shifts never wrap.
- kill:
  - In RUN: return to IDLE on the next edge, with no done pulse; dout_rd keeps its previous value.
  - In DONE: the done pulse still completes; kill only suppresses a simultaneous start.
  - kill wins over start in the same cycle.
- dout_rd changes only on the entry to DONE or on reset.
- Operand ports need not be held stable after acceptance.

Test Plan:
1. Reset held low mid-RUN (cycle 10 of 32) -> busy=0, done=0, dout_rd=0 immediately, asynchronously. After release, no done pulse appears within 40 cycles.
2. clmul, rs1=0x00000003, rs2=0x00000003, BITS_PER_CYCLE=1 -> busy high for 32 cycles, then done for one cycle with dout_rd=0x00000005.
3. rs1=rs2=0xFFFFFFFF -> clmul=0x55555555, clmulh=0x55555555, clmulr=0xAAAAAAAA. Repeat with BITS_PER_CYCLE=4 and confirm done arrives 8 cycles after acceptance.
4. rs1=0x80000000, rs2=0x00000002 -> clmul=0x00000000, clmulh=0x00000001, clmulr=0x00000002.
5. Handshake corners:
   - start during RUN is ignored and the original result is returned.
   - start with funct7=0000000 leaves busy=0 and isZbcInstr=0.
   - start asserted in the DONE cycle produces busy the next cycle and a correct second result, with no idle gap.
6. kill at RUN cycle 5 -> busy=0 next cycle, no done, dout_rd unchanged. start and kill together in IDLE -> no acceptance.

Source files
------------

// File: rtl/zbc_clmul_seq.sv
// Iterative carry-less multiplier for the Zbc clmul/clmulh/clmulr instructions.
// Consumes BITS_PER_CYCLE bits of rs2 per cycle into a 64-bit XOR accumulator
// and presents the selected 32-bit slice of the product with a one-cycle done.
module zbc_clmul_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        kill,
    input  logic [31:0] din_rs1,
    input  logic [31:0] din_rs2,
    input  logic [6:0]  cmdOp,
    input  logic [2:0]  cmdF3,
    input  logic [6:0]  cmdF7,
    output logic        isZbcInstr,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout_rd
);

    localparam int         N    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST = 6'(N - 1);

    localparam logic [6:0] OP_ZBC = 7'b0110011;
    localparam logic [6:0] F7_ZBC = 7'b0000101;
    localparam logic [2:0] F3_CLMUL  = 3'b001;
    localparam logic [2:0] F3_CLMULR = 3'b010;
    localparam logic [2:0] F3_CLMULH = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] rs1_reg;
    logic [31:0] rs2_reg;
    logic [2:0]  sel;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [5:0]  cnt;
    logic        accept;
    logic        last_iter;
    logic [31:0] result;

    // Decode the instruction fields, independent of state and start
    always_comb begin
        isZbcInstr = 1'b0;
        if ((cmdOp == OP_ZBC) && (cmdF7 == F7_ZBC) &&
            ((cmdF3 == F3_CLMUL) || (cmdF3 == F3_CLMULH) || (cmdF3 == F3_CLMULR)))
            isZbcInstr = 1'b1;
    end

    assign accept    = start & isZbcInstr & ~kill & ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == LAST);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // One iteration step: XOR in the shifted rs1 for every set rs2 bit of this slice
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (rs2_reg[k])
                acc_next = acc_next ^ (rs1_reg << k);
        end
    end

    // Pick the product slice for the latched funct3 from the final accumulator
    always_comb begin
        result = 32'd0;
        case (sel)
            F3_CLMUL:  result = acc_next[31:0];
            F3_CLMULH: result = acc_next[63:32];
            F3_CLMULR: result = acc_next[62:31];
            default:   result = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; kill aborts a run, and a start in DONE re-enters RUN directly
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = RUN;
            end
            RUN: begin
                if (kill)
                    state_next = IDLE;
                else if (last_iter)
                    state_next = DONE;
            end
            DONE: begin
                if (accept)
                    state_next = RUN;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_reg <= 64'd0;
            rs2_reg <= 32'd0;
            sel     <= 3'd0;
            acc     <= 64'd0;
            cnt     <= 6'd0;
            dout_rd <= 32'd0;
        end else if (accept) begin
            rs1_reg <= {32'd0, din_rs1};
            rs2_reg <= din_rs2;
            sel     <= cmdF3;
            acc     <= 64'd0;
            cnt     <= 6'd0;
        end else if ((state == RUN) && !kill) begin
            acc     <= acc_next;
            rs1_reg <= rs1_reg << BITS_PER_CYCLE;
            rs2_reg <= rs2_reg >> BITS_PER_CYCLE;
            cnt     <= cnt + 6'd1;
            if (last_iter)
                dout_rd <= result;
        end
    end

endmodule
